// File: rtl/defs.sv
`default_nettype none
// ============================================================================
// Package : defs
// Types shared by the hardwired sequencing controller and its decoder.
// Rev     : 1.0
// ============================================================================
package defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } t_state;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_BEQ  = 4'h6,
    OP_BNE  = 4'h7,
    OP_BLT  = 4'h8,
    OP_BGE  = 4'h9,
    OP_HALT = 4'hF
  } t_opcode;

  // ALU op codes coincide with the ALU opcodes so EXEC/WB can forward IR.op directly.
  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5
  } t_aluop;

  typedef enum logic {
    PC_INC = 1'b0,
    PC_BR  = 1'b1
  } t_pc_sel;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } t_instr;

  typedef struct packed {
    logic eq;
    logic ne;
    logic lt;
    logic ge;
  } t_cmp;

  function automatic logic branch_taken(input logic [3:0] op, input t_cmp c);
    case (op)
      OP_BEQ:  branch_taken = c.eq;
      OP_BNE:  branch_taken = c.ne;
      OP_BLT:  branch_taken = c.lt;
      default: branch_taken = c.ge;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hw_seq_decode.sv
`default_nettype none
// ============================================================================
// Module : hw_seq_decode
// Combinational opcode classifier for the sequencing controller.
// Rev    : 1.0
// ============================================================================
module hw_seq_decode
  import defs::*;
(
  input  logic [3:0] op,
  output logic       is_alu,
  output logic       is_br,
  output logic       is_nop,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    is_alu  = 1'b0;
    is_br   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP:                               is_nop  = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu  = 1'b1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:        is_br   = 1'b1;
      OP_HALT:                              is_halt = 1'b1;
      default:                              illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hw_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hw_seq_ctrl
// Hardwired multi-cycle fetch/decode/execute/writeback/branch controller.
// Rev    : 1.0
// ============================================================================
module hw_seq_ctrl
  import defs::*;
#(
  parameter int unsigned RA_W     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  input  t_cmp             cmp,
  output logic             ir_we,
  output logic [RA_W-1:0]  rf_raddr1,
  output logic [RA_W-1:0]  rf_raddr2,
  output logic [RA_W-1:0]  rf_waddr,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic             flag_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  t_state            state_q, state_d;
  t_instr            ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;
  logic              is_alu, is_br, is_nop, is_halt, illegal;

  hw_seq_decode u_decode (
    .op      (ir_q.op),
    .is_alu  (is_alu),
    .is_br   (is_br),
    .is_nop  (is_nop),
    .is_halt (is_halt),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    alu_op   = ALU_NONE;
    flag_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_INC;
    retire   = 1'b0;
    case (state_q)
      IDLE, HALT: if (start) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (illegal) begin
          state_d = ERR;
        end else if (is_nop || is_halt) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = is_halt ? HALT : FETCH;
        end else if (is_alu) begin
          state_d = EXEC;
        end else if (is_br) begin
          state_d = BRANCH;
        end
      end
      EXEC: begin
        alu_op  = ir_q.op;
        flag_we = 1'b1;
        state_d = WB;
      end
      WB: begin
        alu_op  = ir_q.op;
        rf_we   = !(ZERO_REG && (ir_q.rd == 4'h0));
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        // Compare is done by a SUB in the datapath; cmp reaches pc_sel combinationally.
        alu_op  = ALU_SUB;
        pc_we   = 1'b1;
        pc_sel  = branch_taken(ir_q.op, cmp) ? PC_BR : PC_INC;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = ERR;
    endcase
  end

  assign ir_d      = ir_we ? t_instr'(imem_data) : ir_q;
  assign retired_d = (retire && (retired_q != {CNT_W{1'b1}})) ? retired_q + CNT_W'(1) : retired_q;

  assign rf_raddr1 = RA_W'(ir_q.rs1);
  assign rf_raddr2 = RA_W'(ir_q.rs2);
  assign rf_waddr  = RA_W'(ir_q.rd);
  assign busy      = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
  assign halted    = (state_q == HALT);
  assign err       = (state_q == ERR);
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_hw_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hw_seq_ctrl
// Directed self-checking bench for hw_seq_ctrl (CNT_W=4 to reach saturation).
// Rev    : 1.0
// ============================================================================
module tb_hw_seq_ctrl;
  import defs::*;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_ack;
  logic [15:0] imem_data;
  t_cmp        cmp;
  logic        imem_req, ir_we, rf_we, flag_we, pc_we, pc_sel, busy, halted, err;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
  logic [3:0]  retired;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hw_seq_ctrl #(.RA_W(4), .CNT_W(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_data(imem_data), .cmp(cmp), .ir_we(ir_we), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we), .alu_op(alu_op),
    .flag_we(flag_we), .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0; cmp = '0;
    cyc(); cyc();
    rst_n = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_cmp++; if ({busy, halted, err} !== 3'b000) begin n_bad++; $display("FAIL rst_status got %b exp 000", {busy, halted, err}); end
    n_cmp++; if (retired !== 4'h0) begin n_bad++; $display("FAIL rst_retired got %h exp 0", retired); end
    n_cmp++; if ({alu_op, rf_waddr, rf_raddr1, rf_raddr2} !== 16'h0) begin n_bad++; $display("FAIL rst_fields got %h exp 0000", {alu_op, rf_waddr, rf_raddr1, rf_raddr2}); end
    n_cmp++; if ({rf_we, flag_we, pc_we, pc_sel, ir_we} !== 5'b0) begin n_bad++; $display("FAIL rst_enables got %b exp 00000", {rf_we, flag_we, pc_we, pc_sel, ir_we}); end
  endtask

  // ADD r1,r2,r3 with two wait cycles before ack.
  task automatic test_alu();
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    n_cmp++; if ({imem_req, busy, ir_we} !== 3'b110) begin n_bad++; $display("FAIL alu_fetch1 got %b exp 110", {imem_req, busy, ir_we}); end
    cyc(); #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL alu_fetch2 got %b exp 1", imem_req); end
    cyc(); imem_ack = 1'b1; imem_data = 16'h1123; #1;
    n_cmp++; if ({imem_req, ir_we} !== 2'b11) begin n_bad++; $display("FAIL alu_fetch3 got %b exp 11", {imem_req, ir_we}); end
    cyc(); imem_ack = 1'b0; #1;
    n_cmp++; if ({imem_req, alu_op, rf_we, pc_we} !== 7'b0) begin n_bad++; $display("FAIL alu_decode got %b exp 0", {imem_req, alu_op, rf_we, pc_we}); end
    n_cmp++; if ({rf_waddr, rf_raddr1, rf_raddr2} !== 12'h123) begin n_bad++; $display("FAIL alu_addr got %h exp 123", {rf_waddr, rf_raddr1, rf_raddr2}); end
    cyc(); #1;
    n_cmp++; if ({alu_op, flag_we, rf_we, pc_we} !== 7'b0001_100) begin n_bad++; $display("FAIL alu_exec got %b exp 0001100", {alu_op, flag_we, rf_we, pc_we}); end
    cyc(); #1;
    n_cmp++; if ({alu_op, flag_we, rf_we, pc_we, pc_sel} !== 8'b0001_0110) begin n_bad++; $display("FAIL alu_wb got %b exp 00010110", {alu_op, flag_we, rf_we, pc_we, pc_sel}); end
    n_cmp++; if (retired !== 4'h0) begin n_bad++; $display("FAIL alu_wb_ret got %h exp 0", retired); end
    cyc(); #1;
    n_cmp++; if ({imem_req, rf_we, flag_we} !== 3'b100) begin n_bad++; $display("FAIL alu_next got %b exp 100", {imem_req, rf_we, flag_we}); end
    n_cmp++; if (retired !== 4'h1) begin n_bad++; $display("FAIL alu_retired got %h exp 1", retired); end
  endtask

  // Entered and left in FETCH.
  task automatic test_branch(input logic [15:0] instr, input t_cmp c, input logic exp_sel,
                             input logic [3:0] exp_ret);
    imem_ack = 1'b1; imem_data = instr; #1;
    n_cmp++; if (ir_we !== 1'b1) begin n_bad++; $display("FAIL br_%h_irwe got %b exp 1", instr, ir_we); end
    cyc(); imem_ack = 1'b0; cmp = c; #1;
    n_cmp++; if (pc_we !== 1'b0) begin n_bad++; $display("FAIL br_%h_decode_pcwe got %b exp 0", instr, pc_we); end
    cyc(); #1;
    n_cmp++; if (alu_op !== 4'h2) begin n_bad++; $display("FAIL br_%h_aluop got %h exp 2", instr, alu_op); end
    n_cmp++; if ({pc_we, pc_sel, flag_we, rf_we} !== {1'b1, exp_sel, 2'b00}) begin n_bad++; $display("FAIL br_%h_pc got %b exp %b", instr, {pc_we, pc_sel, flag_we, rf_we}, {1'b1, exp_sel, 2'b00}); end
    cyc(); cmp = '0; #1;
    n_cmp++; if ({imem_req, retired} !== {1'b1, exp_ret}) begin n_bad++; $display("FAIL br_%h_next got %h exp %h", instr, {imem_req, retired}, {1'b1, exp_ret}); end
  endtask

  task automatic test_zero_reg();
    imem_ack = 1'b1; imem_data = 16'h5012;
    cyc(); imem_ack = 1'b0; cyc(); #1;
    n_cmp++; if ({alu_op, flag_we} !== 5'b0101_1) begin n_bad++; $display("FAIL zr_exec got %b exp 01011", {alu_op, flag_we}); end
    cyc(); #1;
    n_cmp++; if ({rf_we, pc_we, rf_waddr} !== 6'b01_0000) begin n_bad++; $display("FAIL zr_wb got %b exp 010000", {rf_we, pc_we, rf_waddr}); end
    cyc(); #1;
    n_cmp++; if (retired !== 4'h5) begin n_bad++; $display("FAIL zr_retired got %h exp 5", retired); end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_data = 16'hF000;
    cyc(); imem_ack = 1'b0; #1;
    n_cmp++; if ({pc_we, pc_sel, halted} !== 3'b100) begin n_bad++; $display("FAIL halt_decode got %b exp 100", {pc_we, pc_sel, halted}); end
    cyc(); #1;
    n_cmp++; if ({halted, busy, imem_req, retired} !== 7'b100_0110) begin n_bad++; $display("FAIL halt_state got %b exp 1000110", {halted, busy, imem_req, retired}); end
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    n_cmp++; if ({imem_req, busy, halted} !== 3'b110) begin n_bad++; $display("FAIL halt_resume got %b exp 110", {imem_req, busy, halted}); end
    rst_n = 1'b0; imem_ack = 1'b1; imem_data = 16'h1123;
    cyc(); rst_n = 1'b1; imem_ack = 1'b0; #1;
    n_cmp++; if ({imem_req, busy, retired} !== 6'b0) begin n_bad++; $display("FAIL halt_midreset got %b exp 000000", {imem_req, busy, retired}); end
    n_cmp++; if (rf_waddr !== 4'h0) begin n_bad++; $display("FAIL halt_ir_clear got %h exp 0", rf_waddr); end
  endtask

  task automatic test_illegal();
    start = 1'b1;
    cyc(); start = 1'b0; imem_ack = 1'b1; imem_data = 16'hB123;
    cyc(); imem_ack = 1'b0; #1;
    n_cmp++; if ({pc_we, busy} !== 2'b01) begin n_bad++; $display("FAIL ill_decode got %b exp 01", {pc_we, busy}); end
    cyc(); #1;
    n_cmp++; if ({err, busy, pc_we, retired} !== 7'b100_0000) begin n_bad++; $display("FAIL ill_err got %b exp 1000000", {err, busy, pc_we, retired}); end
    start = 1'b1; imem_ack = 1'b1;
    cyc(); cyc(); #1;
    n_cmp++; if ({err, imem_req, ir_we, busy} !== 4'b1000) begin n_bad++; $display("FAIL ill_sticky got %b exp 1000", {err, imem_req, ir_we, busy}); end
    start = 1'b0; imem_ack = 1'b0; rst_n = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    n_cmp++; if ({err, busy, halted} !== 3'b000) begin n_bad++; $display("FAIL ill_reset got %b exp 000", {err, busy, halted}); end
  endtask

  task automatic test_saturate();
    start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      imem_ack = 1'b1; imem_data = 16'h0000; #1;
      cyc(); imem_ack = 1'b0; #1;
      n_cmp++; if ({pc_we, pc_sel} !== 2'b10) begin n_bad++; $display("FAIL sat_nop%0d_pc got %b exp 10", i, {pc_we, pc_sel}); end
      cyc(); #1;
      n_cmp++; if (retired !== ((i >= 14) ? 4'hF : 4'(i + 1))) begin n_bad++; $display("FAIL sat_nop%0d_ret got %h exp %h", i, retired, (i >= 14) ? 4'hF : 4'(i + 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch(16'h6012, '{eq: 1'b1, ne: 1'b0, lt: 1'b0, ge: 1'b1}, 1'b1, 4'h2);
    test_branch(16'h7012, '{eq: 1'b1, ne: 1'b0, lt: 1'b0, ge: 1'b1}, 1'b0, 4'h3);
    test_branch(16'h8012, '{eq: 1'b0, ne: 1'b1, lt: 1'b1, ge: 1'b0}, 1'b1, 4'h4);
    test_zero_reg();
    test_halt();
    test_illegal();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
